// File: rtl/cpu_pkg.sv
// Types and widths shared by the memory/writeback stage and its access controller.
package cpu_pkg;

    localparam int DATA_W     = 16;
    localparam int REG_ADDR_W = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        ERROR  = 2'd2
    } mem_state_t;

    typedef struct packed {
        logic reg_write;
        logic mem_read;
        logic mem_write;
        logic halt;
    } xm_ctrl_t;

    typedef struct packed {
        logic reg_write;
        logic halt;
    } mw_ctrl_t;

endpackage

// File: rtl/memory_writeback_stage_dmem_access_ctrl.sv
// Data-memory handshake FSM: issues mem_req, stalls while an access is pending,
// and latches a timeout error when mem_ready never arrives.
module dmem_access_ctrl
    import cpu_pkg::*;
#(
    parameter int MAX_WAIT = 15
) (
    input  logic clk,
    input  logic rst_n,
    input  logic memop,
    input  logic mem_ready,
    output logic mem_req,
    output logic stall_mem,
    output logic mem_timeout
);

    localparam logic [7:0] MAX_CNT = 8'(MAX_WAIT);

    mem_state_t state_q, state_d;
    logic [7:0] wait_cnt_q, wait_cnt_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            wait_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    // The IDLE cycle already counts as the first wait, so ACCESS is entered with 1.
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        case (state_q)
            IDLE: begin
                if (memop && !mem_ready) begin
                    state_d    = ACCESS;
                    wait_cnt_d = 8'd1;
                end
            end
            ACCESS: begin
                if (mem_ready) begin
                    state_d    = IDLE;
                    wait_cnt_d = '0;
                end else if (wait_cnt_q == MAX_CNT) begin
                    state_d = ERROR;
                end else begin
                    wait_cnt_d = wait_cnt_q + 8'd1;
                end
            end
            ERROR:   state_d = ERROR;
            default: begin
                state_d    = IDLE;
                wait_cnt_d = '0;
            end
        endcase
    end

    always_comb begin
        mem_req     = 1'b0;
        stall_mem   = 1'b0;
        mem_timeout = 1'b0;
        case (state_q)
            IDLE: begin
                mem_req   = memop;
                stall_mem = memop & ~mem_ready;
            end
            ACCESS: begin
                mem_req   = 1'b1;
                stall_mem = memop & ~mem_ready;
            end
            ERROR: begin
                stall_mem   = 1'b1;
                mem_timeout = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/memory_writeback_stage.sv
// X/M and M/W pipeline registers plus data-memory access; source of the
// M->X / M->M forwarding values.
module memory_writeback_stage
#(
    parameter int DATA_W     = cpu_pkg::DATA_W,
    parameter int REG_ADDR_W = cpu_pkg::REG_ADDR_W,
    parameter int MAX_WAIT   = 15
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  ex_valid,
    input  logic [DATA_W-1:0]     ex_alu_out,
    input  logic [DATA_W-1:0]     ex_store_data,
    input  logic [REG_ADDR_W-1:0] ex_rt,
    input  logic [REG_ADDR_W-1:0] ex_rd,
    input  logic                  ex_reg_write,
    input  logic                  ex_mem_read,
    input  logic                  ex_mem_write,
    input  logic                  ex_halt,
    input  logic                  b_m2m,
    input  logic [DATA_W-1:0]     mem_rdata,
    input  logic                  mem_ready,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [DATA_W-1:0]     mem_addr,
    output logic [DATA_W-1:0]     mem_wdata,
    output logic                  stall_mem,
    output logic [DATA_W-1:0]     alu_out_xm,
    output logic [REG_ADDR_W-1:0] rt_xm,
    output logic [REG_ADDR_W-1:0] rd_xm,
    output logic                  reg_write_xm,
    output logic                  mem_write_xm,
    output logic [DATA_W-1:0]     writeback_data,
    output logic [REG_ADDR_W-1:0] rd_mw,
    output logic                  reg_write_mw,
    output logic                  halt_mw,
    output logic                  mem_timeout
);
    import cpu_pkg::*;

    logic [DATA_W-1:0]     xm_alu_q, xm_alu_d;
    logic [DATA_W-1:0]     xm_store_q, xm_store_d;
    logic [REG_ADDR_W-1:0] xm_rt_q, xm_rt_d;
    logic [REG_ADDR_W-1:0] xm_rd_q, xm_rd_d;
    xm_ctrl_t              xm_ctrl_q, xm_ctrl_d;

    logic [DATA_W-1:0]     mw_data_q, mw_data_d;
    logic [REG_ADDR_W-1:0] mw_rd_q, mw_rd_d;
    mw_ctrl_t              mw_ctrl_q, mw_ctrl_d;

    logic memop;

    // X/M: a non-valid execute slot becomes an all-zero bubble
    always_comb begin
        xm_alu_d   = '0;
        xm_store_d = '0;
        xm_rt_d    = '0;
        xm_rd_d    = '0;
        xm_ctrl_d  = '0;
        if (ex_valid) begin
            xm_alu_d            = ex_alu_out;
            xm_store_d          = ex_store_data;
            xm_rt_d             = ex_rt;
            xm_rd_d             = ex_rd;
            xm_ctrl_d.reg_write = ex_reg_write;
            xm_ctrl_d.mem_read  = ex_mem_read;
            xm_ctrl_d.mem_write = ex_mem_write;
            xm_ctrl_d.halt      = ex_halt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            xm_alu_q   <= '0;
            xm_store_q <= '0;
            xm_rt_q    <= '0;
            xm_rd_q    <= '0;
            xm_ctrl_q  <= '0;
        end else if (!stall_mem) begin
            xm_alu_q   <= xm_alu_d;
            xm_store_q <= xm_store_d;
            xm_rt_q    <= xm_rt_d;
            xm_rd_q    <= xm_rd_d;
            xm_ctrl_q  <= xm_ctrl_d;
        end
    end

    assign memop = xm_ctrl_q.mem_read | xm_ctrl_q.mem_write;

    dmem_access_ctrl #(
        .MAX_WAIT (MAX_WAIT)
    ) u_dmem_ctrl (
        .clk         (clk),
        .rst_n       (rst_n),
        .memop       (memop),
        .mem_ready   (mem_ready),
        .mem_req     (mem_req),
        .stall_mem   (stall_mem),
        .mem_timeout (mem_timeout)
    );

    // M/W is frozen during a stall, so the forwarded store data stays stable
    assign mem_we    = xm_ctrl_q.mem_write & mem_req;
    assign mem_addr  = xm_alu_q;
    assign mem_wdata = b_m2m ? mw_data_q : xm_store_q;

    always_comb begin
        mw_data_d           = xm_ctrl_q.mem_read ? mem_rdata : xm_alu_q;
        mw_rd_d             = xm_rd_q;
        mw_ctrl_d.reg_write = xm_ctrl_q.reg_write;
        mw_ctrl_d.halt      = xm_ctrl_q.halt;
    end

    // M/W boundary
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mw_data_q <= '0;
            mw_rd_q   <= '0;
            mw_ctrl_q <= '0;
        end else if (!stall_mem) begin
            mw_data_q <= mw_data_d;
            mw_rd_q   <= mw_rd_d;
            mw_ctrl_q <= mw_ctrl_d;
        end
    end

    assign alu_out_xm     = xm_alu_q;
    assign rt_xm          = xm_rt_q;
    assign rd_xm          = xm_rd_q;
    assign reg_write_xm   = xm_ctrl_q.reg_write;
    assign mem_write_xm   = xm_ctrl_q.mem_write;
    assign writeback_data = mw_data_q;
    assign rd_mw          = mw_rd_q;
    assign reg_write_mw   = mw_ctrl_q.reg_write;
    assign halt_mw        = mw_ctrl_q.halt;

endmodule

// File: tb/tb_memory_writeback_stage.sv
// Directed bench for memory_writeback_stage with hand-computed expectations.
module tb_memory_writeback_stage;

    localparam int DW = 16;
    localparam int AW = 4;
    localparam int MW = 15;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          ex_valid;
    logic [DW-1:0] ex_alu_out;
    logic [DW-1:0] ex_store_data;
    logic [AW-1:0] ex_rt;
    logic [AW-1:0] ex_rd;
    logic          ex_reg_write;
    logic          ex_mem_read;
    logic          ex_mem_write;
    logic          ex_halt;
    logic          b_m2m;
    logic [DW-1:0] mem_rdata;
    logic          mem_ready;
    logic          mem_req;
    logic          mem_we;
    logic [DW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          stall_mem;
    logic [DW-1:0] alu_out_xm;
    logic [AW-1:0] rt_xm;
    logic [AW-1:0] rd_xm;
    logic          reg_write_xm;
    logic          mem_write_xm;
    logic [DW-1:0] writeback_data;
    logic [AW-1:0] rd_mw;
    logic          reg_write_mw;
    logic          halt_mw;
    logic          mem_timeout;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    memory_writeback_stage #(
        .DATA_W     (DW),
        .REG_ADDR_W (AW),
        .MAX_WAIT   (MW)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .ex_valid       (ex_valid),
        .ex_alu_out     (ex_alu_out),
        .ex_store_data  (ex_store_data),
        .ex_rt          (ex_rt),
        .ex_rd          (ex_rd),
        .ex_reg_write   (ex_reg_write),
        .ex_mem_read    (ex_mem_read),
        .ex_mem_write   (ex_mem_write),
        .ex_halt        (ex_halt),
        .b_m2m          (b_m2m),
        .mem_rdata      (mem_rdata),
        .mem_ready      (mem_ready),
        .mem_req        (mem_req),
        .mem_we         (mem_we),
        .mem_addr       (mem_addr),
        .mem_wdata      (mem_wdata),
        .stall_mem      (stall_mem),
        .alu_out_xm     (alu_out_xm),
        .rt_xm          (rt_xm),
        .rd_xm          (rd_xm),
        .reg_write_xm   (reg_write_xm),
        .mem_write_xm   (mem_write_xm),
        .writeback_data (writeback_data),
        .rd_mw          (rd_mw),
        .reg_write_mw   (reg_write_mw),
        .halt_mw        (halt_mw),
        .mem_timeout    (mem_timeout)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_bubble();
        ex_valid      = 1'b0;
        ex_alu_out    = '0;
        ex_store_data = '0;
        ex_rt         = '0;
        ex_rd         = '0;
        ex_reg_write  = 1'b0;
        ex_mem_read   = 1'b0;
        ex_mem_write  = 1'b0;
        ex_halt       = 1'b0;
    endtask

    task automatic drive_op(input logic [DW-1:0] alu, input logic [DW-1:0] sd,
                            input logic [AW-1:0] rt, input logic [AW-1:0] rd,
                            input logic rw, input logic mr, input logic mwr, input logic hl);
        ex_valid      = 1'b1;
        ex_alu_out    = alu;
        ex_store_data = sd;
        ex_rt         = rt;
        ex_rd         = rd;
        ex_reg_write  = rw;
        ex_mem_read   = mr;
        ex_mem_write  = mwr;
        ex_halt       = hl;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        drive_bubble();
        b_m2m = 1'b0; mem_rdata = '0; mem_ready = 1'b0;
        step(); step();
        total++; if (alu_out_xm !== 16'h0) begin bad++; $display("FAIL reset_alu_xm got=%h want=0000", alu_out_xm); end
        total++; if (writeback_data !== 16'h0) begin bad++; $display("FAIL reset_wb got=%h want=0000", writeback_data); end
        total++; if ({mem_req, stall_mem, mem_timeout, reg_write_mw} !== 4'b0) begin bad++; $display("FAIL reset_ctrl got=%b want=0000", {mem_req, stall_mem, mem_timeout, reg_write_mw}); end
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_alu_op();
        drive_op(16'h0042, 16'h0, 4'd0, 4'd3, 1'b1, 1'b0, 1'b0, 1'b0);
        step();
        drive_bubble();
        #1;
        total++; if (rd_xm !== 4'd3) begin bad++; $display("FAIL alu_rd_xm got=%0d want=3", rd_xm); end
        total++; if (alu_out_xm !== 16'h0042) begin bad++; $display("FAIL alu_out_xm got=%h want=0042", alu_out_xm); end
        total++; if ({stall_mem, mem_req} !== 2'b00) begin bad++; $display("FAIL alu_no_stall got=%b want=00", {stall_mem, mem_req}); end
        step();
        total++; if (writeback_data !== 16'h0042) begin bad++; $display("FAIL alu_wb got=%h want=0042", writeback_data); end
        total++; if (rd_mw !== 4'd3 || reg_write_mw !== 1'b1) begin bad++; $display("FAIL alu_mw got rd=%0d we=%b want rd=3 we=1", rd_mw, reg_write_mw); end
        total++; if (stall_mem !== 1'b0) begin bad++; $display("FAIL alu_stall2 got=%b want=0", stall_mem); end
    endtask

    task automatic test_halt();
        drive_op(16'h0, 16'h0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        step();
        drive_bubble();
        step();
        total++; if (halt_mw !== 1'b1) begin bad++; $display("FAIL halt_mw got=%b want=1", halt_mw); end
        step();
        total++; if (halt_mw !== 1'b0) begin bad++; $display("FAIL halt_clear got=%b want=0", halt_mw); end
    endtask

    task automatic test_load_wait();
        int reqs = 0, stalls = 0, wes = 0, addr_bad = 0;
        drive_op(16'h0010, 16'h0, 4'd0, 4'd7, 1'b1, 1'b1, 1'b0, 1'b0);
        mem_ready = 1'b0;
        step();
        drive_bubble();
        for (int c = 1; c <= 4; c++) begin
            if (c == 4) begin mem_ready = 1'b1; mem_rdata = 16'hBEEF; end
            #1;
            if (mem_req === 1'b1) reqs++;
            if (stall_mem === 1'b1) stalls++;
            if (mem_we !== 1'b0) wes++;
            if (mem_addr !== 16'h0010) addr_bad++;
            step();
        end
        mem_ready = 1'b0; mem_rdata = '0;
        #1;
        total++; if (reqs != 4) begin bad++; $display("FAIL load_req_cycles got=%0d want=4", reqs); end
        total++; if (stalls != 3) begin bad++; $display("FAIL load_stall_cycles got=%0d want=3", stalls); end
        total++; if (wes != 0 || addr_bad != 0) begin bad++; $display("FAIL load_drive got we=%0d addr_bad=%0d want 0 0", wes, addr_bad); end
        total++; if (writeback_data !== 16'hBEEF) begin bad++; $display("FAIL load_wb got=%h want=beef", writeback_data); end
        total++; if (reg_write_mw !== 1'b1 || rd_mw !== 4'd7) begin bad++; $display("FAIL load_mw got we=%b rd=%0d want we=1 rd=7", reg_write_mw, rd_mw); end
    endtask

    task automatic test_store_forward();
        drive_op(16'h1234, 16'h0, 4'd0, 4'd5, 1'b1, 1'b0, 1'b0, 1'b0);
        step();
        drive_op(16'h0020, 16'h0000, 4'd5, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        step();
        drive_bubble();
        #1;
        total++; if (mem_write_xm !== 1'b1 || rt_xm !== 4'd5) begin bad++; $display("FAIL st_xm got mw=%b rt=%0d want mw=1 rt=5", mem_write_xm, rt_xm); end
        total++; if ({mem_req, mem_we, stall_mem} !== 3'b111) begin bad++; $display("FAIL st_req got=%b want=111", {mem_req, mem_we, stall_mem}); end
        total++; if (mem_addr !== 16'h0020) begin bad++; $display("FAIL st_addr got=%h want=0020", mem_addr); end
        total++; if (mem_wdata !== 16'h0000) begin bad++; $display("FAIL st_wdata_nofwd got=%h want=0000", mem_wdata); end
        b_m2m = 1'b1;
        #1;
        total++; if (mem_wdata !== 16'h1234) begin bad++; $display("FAIL st_wdata_fwd got=%h want=1234", mem_wdata); end
        mem_ready = 1'b1;
        #1;
        total++; if (stall_mem !== 1'b0) begin bad++; $display("FAIL st_zero_wait got=%b want=0", stall_mem); end
        step();
        mem_ready = 1'b0; b_m2m = 1'b0;
        #1;
        total++; if (mem_req !== 1'b0 || reg_write_mw !== 1'b0) begin bad++; $display("FAIL st_after got req=%b we=%b want 0 0", mem_req, reg_write_mw); end
    endtask

    task automatic test_timeout();
        int reqs = 0, unstable = 0, errs = 0;
        drive_op(16'h0030, 16'hA5A5, 4'd2, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        mem_ready = 1'b0;
        step();
        drive_bubble();
        for (int i = 0; i < 40; i++) begin
            if (mem_timeout === 1'b1) break;
            if (mem_req === 1'b1) reqs++;
            if (mem_addr !== 16'h0030 || mem_wdata !== 16'hA5A5 || mem_we !== 1'b1) unstable++;
            step();
        end
        total++; if (mem_timeout !== 1'b1) begin bad++; $display("FAIL to_reached got=%b want=1", mem_timeout); end
        total++; if (reqs != MW + 1) begin bad++; $display("FAIL to_req_cycles got=%0d want=%0d", reqs, MW + 1); end
        total++; if (unstable != 0) begin bad++; $display("FAIL to_stable got=%0d want=0", unstable); end
        mem_ready = 1'b1;
        for (int i = 0; i < 50; i++) begin
            if (mem_req !== 1'b0 || mem_we !== 1'b0 || stall_mem !== 1'b1 || mem_timeout !== 1'b1) errs++;
            step();
        end
        total++; if (errs != 0) begin bad++; $display("FAIL to_sticky got=%0d bad cycles want=0", errs); end
        rst_n = 1'b0;
        #1;
        total++; if ({mem_timeout, stall_mem, mem_req, mem_write_xm} !== 4'b0) begin bad++; $display("FAIL to_reset got=%b want=0000", {mem_timeout, stall_mem, mem_req, mem_write_xm}); end
        #2;
        rst_n = 1'b1;
        mem_ready = 1'b0;
        step();
        total++; if ({mem_timeout, stall_mem} !== 2'b00) begin bad++; $display("FAIL to_after_reset got=%b want=00", {mem_timeout, stall_mem}); end
    endtask

    task automatic test_reset_mid_access();
        drive_op(16'h5555, 16'h0, 4'd0, 4'd9, 1'b1, 1'b0, 1'b0, 1'b0);
        step();
        drive_op(16'h0040, 16'h0, 4'd0, 4'd4, 1'b1, 1'b1, 1'b0, 1'b0);
        mem_ready = 1'b0;
        step();
        drive_bubble();
        step();
        step();
        #1;
        total++; if (mem_req !== 1'b1 || writeback_data !== 16'h5555) begin bad++; $display("FAIL mid_pre got req=%b wb=%h want 1 5555", mem_req, writeback_data); end
        rst_n = 1'b0;
        #1;
        total++; if ({mem_req, stall_mem, reg_write_mw, reg_write_xm} !== 4'b0) begin bad++; $display("FAIL mid_ctrl got=%b want=0000", {mem_req, stall_mem, reg_write_mw, reg_write_xm}); end
        total++; if (writeback_data !== 16'h0 || alu_out_xm !== 16'h0 || rd_xm !== 4'd0 || rd_mw !== 4'd0) begin bad++; $display("FAIL mid_data got wb=%h alu=%h rd_xm=%0d rd_mw=%0d want all 0", writeback_data, alu_out_xm, rd_xm, rd_mw); end
        #2;
        rst_n = 1'b1;
        step();
        total++; if ({mem_req, stall_mem} !== 2'b00) begin bad++; $display("FAIL mid_idle got=%b want=00", {mem_req, stall_mem}); end
    endtask

    task automatic test_bubble();
        ex_valid = 1'b0; ex_reg_write = 1'b1; ex_mem_read = 1'b1;
        ex_rd = 4'd6; ex_alu_out = 16'h0077;
        step();
        drive_bubble();
        #1;
        total++; if ({reg_write_xm, mem_req, stall_mem} !== 3'b000) begin bad++; $display("FAIL bub_xm got=%b want=000", {reg_write_xm, mem_req, stall_mem}); end
        total++; if (alu_out_xm !== 16'h0 || rd_xm !== 4'd0) begin bad++; $display("FAIL bub_data got alu=%h rd=%0d want 0 0", alu_out_xm, rd_xm); end
        step();
        total++; if (reg_write_mw !== 1'b0) begin bad++; $display("FAIL bub_mw got=%b want=0", reg_write_mw); end
    endtask

    task automatic test_back_to_back();
        mem_ready = 1'b1;
        drive_op(16'h0100, 16'h0, 4'd0, 4'd1, 1'b1, 1'b1, 1'b0, 1'b0);
        step();
        drive_op(16'h0102, 16'h0, 4'd0, 4'd2, 1'b1, 1'b1, 1'b0, 1'b0);
        mem_rdata = 16'h1111;
        #1;
        total++; if (stall_mem !== 1'b0 || mem_addr !== 16'h0100) begin bad++; $display("FAIL b2b_first got stall=%b addr=%h want 0 0100", stall_mem, mem_addr); end
        step();
        drive_bubble();
        mem_rdata = 16'h2222;
        #1;
        total++; if (writeback_data !== 16'h1111 || rd_mw !== 4'd1) begin bad++; $display("FAIL b2b_wb1 got wb=%h rd=%0d want 1111 1", writeback_data, rd_mw); end
        total++; if (mem_addr !== 16'h0102 || stall_mem !== 1'b0) begin bad++; $display("FAIL b2b_second got addr=%h stall=%b want 0102 0", mem_addr, stall_mem); end
        step();
        total++; if (writeback_data !== 16'h2222 || rd_mw !== 4'd2) begin bad++; $display("FAIL b2b_wb2 got wb=%h rd=%0d want 2222 2", writeback_data, rd_mw); end
        mem_ready = 1'b0; mem_rdata = '0;
    endtask

    initial begin
        test_reset();
        test_alu_op();
        test_halt();
        test_load_wait();
        test_store_forward();
        test_timeout();
        test_reset_mid_access();
        test_bubble();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
